stream_feeder: RTL
==================

Name: stream_feeder

Overview:
- Source-side partner of the reduction engines: a BUFFER_DEPTH-word local buffer that is loaded by a host write port and then replayed as a counted stream.
- Output is a 32-bit valid/ready stream with a last marker; one start launches exactly one frame of BUFFER_DEPTH words.
- With out_ready tied high it produces BUFFER_DEPTH back-to-back valid cycles. That is exactly the frame a downstream reduce_sum (in_data/in_valid) consumes to emit one result.

Parameters:
- DATA_W, 32, stream and buffer word width.
- BUFFER_DEPTH, 512, words per frame and buffer size (power of two, >= 4).
- ADDR_W, 9, address width = clog2(BUFFER_DEPTH).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- wr_en  input  1  buffer write strobe.
- wr_addr  input  ADDR_W  buffer write address.
- wr_data  input  DATA_W  buffer write data.
- start  input  1  launch one frame (sampled when idle).
- busy  output  1  high from accepted start until done.
- out_data  output  DATA_W  stream word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts word; handshake = out_valid & out_ready.
- out_last  output  1  high with word BUFFER_DEPTH-1.
- done  output  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset (rst low, async assert, sync release):
  - busy, out_valid, out_last and done = 0; out_data = 0.
  - State returns to IDLE; read pointer and emitted-word counter = 0.
  - Buffer contents are not cleared and are retained across reset.
- Buffer:
  - Single-port write, synchronous read, one-cycle read latency.
  - A write is accepted only in IDLE with wr_en = 1; writes while busy are ignored (memory unchanged).
  - wr_addr >= BUFFER_DEPTH is ignored (only matters for non-power-of-two depths, which are illegal).
- States:
  - IDLE: busy = 0. start = 1 -> PRIME, busy = 1, read pointer = 0.
  - PRIME: issue read of addr 0; next state STREAM.
  - STREAM: the output register holds the current word.
    - Handshake at word i < BUFFER_DEPTH-1 loads word i+1 on the next edge; out_valid stays high, so there are no bubbles with out_ready = 1.
    - The buffer is read one address ahead (prefetch/skid), so a handshake every cycle is sustainable.
    - The next read is issued only when the output register will be free.
  - DONE: reached after the handshake of word BUFFER_DEPTH-1.
    - out_valid = 0, done = 1 for exactly one cycle, busy = 0 in the same cycle.
    - The state then returns to IDLE; a start sampled in the DONE cycle is accepted.
- Latency: out_valid first rises exactly 2 cycles after the edge that samples start.
- Stream rules:
  - While out_valid = 1 and out_ready = 0, out_data and out_last are held stable.
  - out_valid never drops before the handshake.
  - Word i of a frame = buffer[i], in ascending order; each word is emitted exactly once (no drop, no duplicate).
  - out_last = 1 only with word BUFFER_DEPTH-1.
- Ignored inputs: start while busy is ignored (no restart, no queueing).
- Counters: the emitted-word counter is ADDR_W+1 bits and terminates at BUFFER_DEPTH; the read pointer never wraps within a frame.
- Reset mid-frame: the stream aborts immediately and the outputs take their reset values, with no done pulse. The next start replays from addr 0.
- out_ready is ignored whenever out_valid = 0.

Test Plan:
- Load buffer[i] = i for i = 0..511, start, out_ready = 1 -> out_valid high on 512 consecutive cycles starting 2 cycles after start. Data runs 0..511, out_last only on 511, done one cycle later. A downstream sum of the words = 130816.
- Same load, out_ready toggling 1,0,1,0 (and a random pattern) -> out_data stable while stalled, 512 handshakes carrying 0..511 in order, done pulses once.
- During a frame: assert start, and write buffer[5] = 0xDEADBEEF -> the frame is unaffected. A second start after done replays buffer[5] = 5.
- Assert rst low after the 100th handshake -> all outputs 0 asynchronously, no done. A new start streams from word 0 with full 512-word length.
- Hold start high continuously with out_ready = 1 -> frames run back-to-back with restart accepted in each DONE cycle, done pulses once per frame, busy low only in the DONE cycles.
- Reduced-depth build: BUFFER_DEPTH = 4, ADDR_W = 2, buffer = {7,8,9,10} -> 4 words 7,8,9,10, out_last on 10, done, busy deasserted.

Source files
------------

// File: rtl/stream_feeder.sv
// stream_feeder: BUFFER_DEPTH-word local buffer loaded by a host write port
// and replayed as one counted valid/ready frame per start.
module stream_feeder #(
  parameter int DATA_W       = 32,
  parameter int BUFFER_DEPTH = 512,
  parameter int ADDR_W       = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  output logic              busy,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    STREAM,
    FIN
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(BUFFER_DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(BUFFER_DEPTH-1);

  logic [DATA_W-1:0] mem [BUFFER_DEPTH];

  state_t state, state_nx;

  logic [ADDR_W:0]   rp, rp_nx;
  logic [ADDR_W:0]   cnt, cnt_nx;
  logic              rv, rv_nx;
  logic [DATA_W-1:0] rdata;
  logic              ov, ov_nx;
  logic [DATA_W-1:0] od, od_nx;

  logic hs;
  logic load;
  logic rd_issue;
  logic wr_ok;

  assign hs    = ov & out_ready;
  assign wr_ok = (state == IDLE) & wr_en
               & ({1'b0, wr_addr} < DEPTH_C);

  // rdata/rv form a one-entry skid behind the output register, so a
  // read is only issued when its landing slot is guaranteed free.
  always_comb begin
    state_nx = state;
    rp_nx    = rp;
    cnt_nx   = cnt;
    rv_nx    = rv;
    ov_nx    = ov;
    od_nx    = od;
    load     = 1'b0;
    rd_issue = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = PRIME;
          rp_nx    = '0;
          cnt_nx   = '0;
        end
      end
      PRIME, STREAM: begin
        load     = rv & (~ov | hs);
        rd_issue = (rp < DEPTH_C) & (~rv | load);
        if (rd_issue) begin
          rp_nx = rp + 1'b1;
          rv_nx = 1'b1;
        end else if (load) begin
          rv_nx = 1'b0;
        end
        if (load) begin
          ov_nx = 1'b1;
          od_nx = rdata;
        end else if (hs) begin
          ov_nx = 1'b0;
        end
        if (hs) cnt_nx = cnt + 1'b1;
        if (state == PRIME) begin
          state_nx = STREAM;
        end else if (hs && cnt == LAST_C) begin
          state_nx = FIN;
        end
      end
      FIN: begin
        if (start) begin
          state_nx = PRIME;
          rp_nx    = '0;
          cnt_nx   = '0;
        end else begin
          state_nx = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rp    <= '0;
      cnt   <= '0;
      rv    <= 1'b0;
      ov    <= 1'b0;
      od    <= '0;
    end else begin
      state <= state_nx;
      rp    <= rp_nx;
      cnt   <= cnt_nx;
      rv    <= rv_nx;
      ov    <= ov_nx;
      od    <= od_nx;
    end
  end

  // Buffer array has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
    if (rd_issue) rdata <= mem[rp[ADDR_W-1:0]];
  end

  assign busy      = (state == PRIME) | (state == STREAM);
  assign done      = (state == FIN);
  assign out_valid = ov;
  assign out_data  = od;
  assign out_last  = ov & (cnt == LAST_C);

endmodule
